// File: rtl/rr_scheduler4_pkg.sv
// Shared definitions for the rr_scheduler4 round-robin scheduler.
//   - FSM state encodings (IDLE / GRANT / GAP)
//   - NREQ  : number of requesters
//   - PTR_W : width of the round-robin pointer and owner index
package rr_sched_pkg;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned PTR_W = 2;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t GRANT = 2'd1;
  localparam state_t GAP   = 2'd2;

endpackage

// File: rtl/rr_scheduler4_if.sv
// Handshake bundle between the requesting state machines and the scheduler.
//   req     : one request bit per requester
//   done    : current owner finished
//   gnt     : one-hot grant (zero when no owner)
//   gnt_id  : binary owner index, valid while busy
//   busy    : a grant is active
//   timeout : one-cycle pulse on a hold-limit release
// master = requester side, slave = scheduler side.
interface rr_scheduler4_if;
  import rr_sched_pkg::*;

  logic [NREQ-1:0]  req;
  logic             done;
  logic [NREQ-1:0]  gnt;
  logic [PTR_W-1:0] gnt_id;
  logic             busy;
  logic             timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_id,
    output busy,
    output timeout
  );

endinterface

// File: rtl/rr_scheduler4_pick.sv
// rr_pick4: combinational circular priority encoder.
//   req      : request vector
//   ptr      : highest-priority position
//   pick_id  : first set bit scanning ptr, ptr+1, ... (mod NREQ)
//   pick_vld : at least one request set
module rr_pick4 import rr_sched_pkg::*; (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] pick_id,
  output logic             pick_vld
);

  logic [PTR_W-1:0] idx;

  // Scan from the farthest offset down to ptr so the closest hit wins.
  always_comb begin
    idx      = '0;
    pick_id  = ptr;
    pick_vld = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = ptr + PTR_W'(i);
      if (req[idx]) begin
        pick_id  = idx;
        pick_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_scheduler4.sv
// rr_scheduler4: round-robin owner arbitration for one shared resource.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset
//   sched : slave side of rr_scheduler4_if (req/done in, gnt/gnt_id/busy/timeout out)
// One owner at a time; ownership ends on done, dropped request or after HOLD_MAX
// cycles, followed by a single dead (GAP) cycle. All outputs are registered.
module rr_scheduler4 import rr_sched_pkg::*; #(
  parameter int unsigned HOLD_MAX = 8  // legal 2..256
) (
  input  logic                  clk,
  input  logic                  rst,
  rr_scheduler4_if.slave        sched
);

  localparam int unsigned         CNT_W    = $clog2(HOLD_MAX);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [NREQ-1:0]     GNT_ONE  = NREQ'(1);

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [PTR_W-1:0] id_q, id_d;
  logic             busy_q, busy_d;
  logic             to_q, to_d;

  logic [PTR_W-1:0] pick_id;
  logic             pick_vld;
  logic             at_limit;
  logic             owner_req;
  logic             release_now;

  rr_pick4 u_pick (
    .req      (sched.req),
    .ptr      (ptr_q),
    .pick_id  (pick_id),
    .pick_vld (pick_vld)
  );

  assign at_limit    = (cnt_q == CNT_LAST);
  assign owner_req   = sched.req[id_q];
  assign release_now = sched.done | ~owner_req | at_limit;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    busy_d  = busy_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d   = GNT_ONE << pick_id;
          id_d    = pick_id;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = id_q + PTR_W'(1);
          // Only a release caused by the hold limit alone counts as forced.
          to_d    = at_limit & ~sched.done & owner_req;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      id_q    <= '0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
    end
  end

  assign sched.gnt     = gnt_q;
  assign sched.gnt_id  = id_q;
  assign sched.busy    = busy_q;
  assign sched.timeout = to_q;

endmodule

// File: tb/tb_rr_scheduler4.sv
// Self-checking bench for rr_scheduler4: directed scenarios plus randomized
// traffic, all compared against a cycle-level ownership model.
module tb_rr_scheduler4;

  localparam int unsigned HOLD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rr_scheduler4_if sched_if ();

  rr_scheduler4 #(
    .HOLD_MAX (HOLD)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sched (sched_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: who owns the resource, how long, and whether a dead cycle is due.
  int m_owner;   // -1 = nobody
  int m_held;    // cycles the current owner has held the resource
  int m_ptr;     // first requester examined at the next arbitration
  bit m_gap;     // dead cycle pending
  bit m_to;      // expected timeout output

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 0;
    m_gap   = 1'b0;
    m_to    = 1'b0;
  endtask

  task automatic model_update(input logic [3:0] r, input logic d);
    m_to = 1'b0;
    if (m_owner >= 0) begin
      m_held++;
      if (d || !r[m_owner] || m_held == HOLD) begin
        m_to    = (m_held == HOLD) && !d && r[m_owner];
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_gap   = 1'b1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_held  = 0;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] exp_gnt;
    exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    check({tag, ".gnt"}, 32'(sched_if.gnt), 32'(exp_gnt));
    check({tag, ".busy"}, 32'(sched_if.busy), 32'(m_owner >= 0));
    if (m_owner >= 0) check({tag, ".gnt_id"}, 32'(sched_if.gnt_id), 32'(m_owner));
    check({tag, ".timeout"}, 32'(sched_if.timeout), 32'(m_to));
  endtask

  // Drive inputs for one cycle, advance the model on the edge, check half a cycle later.
  task automatic cycle(input string tag, input logic [3:0] r, input logic d);
    sched_if.req  = r;
    sched_if.done = d;
    @(posedge clk);
    model_update(r, d);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    sched_if.req  = '0;
    sched_if.done = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_outputs("reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] r;
    logic       d;
    int         order [5] = '{0, 1, 2, 3, 0};

    sched_if.req  = '0;
    sched_if.done = 1'b0;
    model_reset();
    do_reset();

    // Asynchronous reset in the middle of a grant to requester 2.
    cycle("rst_pre", 4'b0100, 1'b0);
    cycle("rst_pre", 4'b0100, 1'b0);
    check("rst_pre_gnt", 32'(sched_if.gnt), 32'h4);
    #2 rst = 1'b1;
    #1;
    check("async_rst_gnt", 32'(sched_if.gnt), 32'h0);
    check("async_rst_busy", 32'(sched_if.busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle("rst_post", 4'b0001, 1'b0);
    check("rst_post_gnt", 32'(sched_if.gnt), 32'h1);

    // Fairness: all requesting, done after each grant.
    do_reset();
    for (int g = 0; g < 5; g++) begin
      cycle("fair", 4'b1111, 1'b0);
      check("fair_order", 32'(sched_if.gnt_id), 32'(order[g]));
      cycle("fair", 4'b1111, 1'b1);
      check("fair_gap1", 32'(sched_if.gnt), 32'h0);
      cycle("fair", 4'b1111, 1'b0);
      check("fair_gap2", 32'(sched_if.gnt), 32'h0);
    end

    // Pointer wrap 3 -> 0.
    do_reset();
    cycle("wrap", 4'b1000, 1'b0);
    cycle("wrap", 4'b1000, 1'b1);
    cycle("wrap", 4'b1001, 1'b0);
    cycle("wrap", 4'b1001, 1'b0);
    check("wrap_gnt", 32'(sched_if.gnt), 32'h1);

    // Hold limit: exactly HOLD cycles of grant, then a one-cycle timeout.
    do_reset();
    for (int i = 0; i < HOLD; i++) begin
      cycle("hold", 4'b0010, 1'b0);
      check("hold_gnt", 32'(sched_if.gnt), 32'h2);
    end
    cycle("hold", 4'b0010, 1'b0);
    check("hold_timeout", 32'(sched_if.timeout), 32'h1);
    check("hold_released", 32'(sched_if.gnt), 32'h0);
    cycle("hold", 4'b0101, 1'b0);
    check("hold_timeout_end", 32'(sched_if.timeout), 32'h0);
    cycle("hold", 4'b0101, 1'b0);
    check("hold_ptr2", 32'(sched_if.gnt), 32'h4);

    // done coinciding with the hold limit: no timeout.
    do_reset();
    for (int i = 0; i < HOLD; i++) cycle("simul", 4'b0010, 1'b0);
    cycle("simul", 4'b0010, 1'b1);
    check("simul_gnt", 32'(sched_if.gnt), 32'h0);
    check("simul_timeout", 32'(sched_if.timeout), 32'h0);

    // Owner 2 drops its request; pointer at 3 but requester 0 wins.
    do_reset();
    cycle("drop", 4'b0100, 1'b0);
    cycle("drop", 4'b0011, 1'b0);
    check("drop_gnt", 32'(sched_if.gnt), 32'h0);
    cycle("drop", 4'b0011, 1'b0);
    cycle("drop", 4'b0011, 1'b0);
    check("drop_winner", 32'(sched_if.gnt), 32'h1);

    // Randomized traffic; requests tend to persist so holds run long.
    do_reset();
    r = '0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 9) == 0);
      cycle("rand", r, d);
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/rr_scheduler4.md
# rr_scheduler4

Round-robin scheduler that shares one counter-driven resource among four requesters. It grants exactly one requester at a time. Ownership is held until the owner signals completion, drops its request, or hits a hold limit. A 2-bit wrapping priority pointer gives fairness. The block sits between the requesting state machines and the shared resource, and its one-hot grant gates that resource's enable.

## Interface
- `HOLD_MAX`, default 8: maximum cycles a grant is held before forced release. Legal range is 2 to 256.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  4  request per requester; bit i belongs to requester i.
- `done`  in  1  the current owner finished; sampled only in GRANT.
- `gnt`  out  4  one-hot grant, registered; all zeros when nobody owns the resource.
- `gnt_id`  out  2  binary index of the owner; valid only while `busy`=1.
- `busy`  out  1  high while in GRANT.
- `timeout`  out  1  one-cycle pulse when a grant is force-released by `HOLD_MAX`.

## Operation
- **States.**
  - IDLE: no owner.
  - GRANT: one owner.
  - GAP: mandatory one-cycle dead cycle after every release.
- **IDLE.**
  - If `req`≠0, pick the first set bit scanning circularly from `ptr`, i.e. ptr, ptr+1, ptr+2, ptr+3 mod 4.
  - At the next edge: load `gnt`/`gnt_id`, set `busy`, clear `hold_cnt`, go to GRANT.
  - If `req`=0, stay in IDLE.
- **GRANT.** Release on the edge where any of these is true:
  - `done`=1;
  - `req[gnt_id]`=0;
  - `hold_cnt`=HOLD_MAX-1. In this case `timeout` pulses high for the following cycle only.
  - Otherwise `hold_cnt` increments.
- **On release.**
  - `gnt`←0, `busy`←0, `ptr`←`gnt_id`+1, wrapping 3→0 in 2-bit arithmetic. Go to GAP.
- **GAP.** `gnt`=0; go unconditionally to IDLE. No arbitration takes place in GAP.
- **Pointer.** `ptr` changes only on release. A requester released with `ptr` at 3 wraps the pointer to 0.
- **Counter width.** `hold_cnt` is clog2(HOLD_MAX) bits and never exceeds HOLD_MAX-1.
- **Simultaneous events.**
  - `done` together with the hold limit is a normal release with no `timeout`.
  - `done` together with a dropped `req` is a single release.
  - Requests from non-owners during GRANT or GAP are ignored until IDLE.
- **Reset.** Asserting `rst` in any state immediately forces the following, with no glitch on `gnt` after deassertion:
  - state=IDLE, `ptr`=0, `hold_cnt`=0;
  - `gnt`=0000, `gnt_id`=00, `busy`=0, `timeout`=0.
- **Invariant.** `gnt` is always zero or one-hot; `busy`=|`gnt`.

## Timing
- **Grant latency.** `req` is sampled high in IDLE at edge k. `gnt`/`busy` are high after edge k, i.e. in cycle k+1.
- **Release latency.** The release condition is sampled at edge m. `gnt`=0 from cycle m+1 (GAP). Earliest next grant is visible in cycle m+3: IDLE samples at m+2.
- **Maximum hold.** With `req` held and no `done`, `gnt` stays high for exactly HOLD_MAX cycles.
- **Turnaround.** Minimum time between consecutive grants is 2 idle-grant cycles (GAP plus IDLE).
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package `rr_sched_pkg`:
  - state enum IDLE=2'd0, GRANT=2'd1, GAP=2'd2;
  - constant `NREQ`=4;
  - constant `PTR_W`=2.
- Sub-module `rr_pick4`: purely combinational circular priority encoder. Inputs are `req[3:0]` and `ptr[1:0]`. Outputs are `pick_id[1:0]` and `pick_vld`.
- The top level holds the FSM, `ptr`, `hold_cnt` and the output registers.

## Test plan
1. **Reset.** Assert `rst` mid-GRANT with `gnt`=0100 → `gnt`=0000, `busy`=0 immediately. After release, `req`=0001 → `gnt`=0001 one cycle after sampling, since `ptr` is 0.
2. **Fairness.** Hold `req`=1111 and pulse `done` after each grant → grant order 0,1,2,3,0. Each grant is separated by exactly 2 `gnt`=0 cycles.
3. **Wrap.** From reset, `req`=1000 until `done` → `ptr`=0. Then `req`=1001 → requester 0 wins before requester 3.
4. **Timeout.** With HOLD_MAX=8, `req`=0010 held and `done`=0 → `gnt`=0010 for 8 cycles, then `timeout`=1 for exactly one cycle, `ptr`=2.
5. **Simultaneous.** `done`=1 on the same edge as `hold_cnt`=7 → release with `timeout` staying 0.
6. **Drop request.** Owner 2 deasserts `req[2]` while `req`=0011 → release next edge, GAP, then grant to requester 3 is skipped and requester 0 wins.
